umem_arbiter: RTL and testbench

//  Shares one single-ported unified memory between the pipeline's instruction-fetch (I) port
//  and MEM-stage data (D) port. Sits between the CPU core and the memory model.

---
 rtl/umem_arbiter.sv | 162 ++++++++++++++++
 tb/tb_umem_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/umem_arbiter.sv
// umem_arbiter: shares one single-ported unified memory between the instruction-fetch (I)
// port and the MEM-stage data (D) port. D has priority; a burst counter forces one I grant
// after MAX_DBURST back-to-back D grants while I is waiting. An optional timeout aborts an
// access whose m_ack never arrives.
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-low reset
//   i_req/i_addr             I-port read request, held until i_ready
//   i_rdata/i_ready          fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata D-port request, held until d_ready
//   d_rdata/d_ready          load data and one-cycle completion pulse
//   m_req/m_we/m_addr/m_wdata memory request (m_req held until m_ack), fields latched at grant
//   m_rdata/m_ack            memory read data and completion
//   stall                    combinational pipeline freeze
//   timeout                  one-cycle pulse alongside the ready of an aborted access
module umem_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned MAX_DBURST = 4,
    parameter int unsigned TIMEOUT    = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic [DW-1:0] i_rdata,
    output logic          i_ready,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic [DW-1:0] d_rdata,
    output logic          d_ready,
    output logic          m_req,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    input  logic          m_ack,
    output logic          stall,
    output logic          timeout
);

    localparam int unsigned CW = $clog2(MAX_DBURST + 1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] BURST_MAX  = CW'(MAX_DBURST);
    localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT - 1);
    localparam logic [DW-1:0] ABORT_DATA = DW'(32'hDEAD_BEEF);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BUSY_I = 3'd1,
        BUSY_D = 3'd2,
        DONE_I = 3'd3,
        DONE_D = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] burst_q, burst_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic          grant_i, grant_d;
    logic          ld_i, ld_d;
    logic          abort_i, abort_d;
    logic          expire;

    // Last BUSY cycle allowed before the access is abandoned
    assign expire = (TIMEOUT != 0) && (tcnt_q == TO_LAST);

    // Next-state, arbitration and load strobes
    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        tcnt_d  = '0;
        grant_i = 1'b0;
        grant_d = 1'b0;
        ld_i    = 1'b0;
        ld_d    = 1'b0;
        abort_i = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req && !(i_req && burst_q == BURST_MAX)) begin
                    grant_d = 1'b1;
                    state_d = BUSY_D;
                    // The grant guard already stops the count at BURST_MAX
                    burst_d = i_req ? burst_q + CW'(1) : '0;
                end else if (i_req) begin
                    grant_i = 1'b1;
                    state_d = BUSY_I;
                    burst_d = '0;
                end
            end
            BUSY_I: begin
                if (m_ack) begin
                    ld_i    = 1'b1;
                    state_d = DONE_I;
                end else if (expire) begin
                    abort_i = 1'b1;
                    state_d = DONE_I;
                end else if (TIMEOUT != 0) begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            BUSY_D: begin
                if (m_ack) begin
                    ld_d    = !m_we;
                    state_d = DONE_D;
                end else if (expire) begin
                    abort_d = 1'b1;
                    state_d = DONE_D;
                end else if (TIMEOUT != 0) begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, counters, memory command and read-data registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            burst_q <= '0;
            tcnt_q  <= '0;
            m_we    <= 1'b0;
            m_addr  <= '0;
            m_wdata <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
            timeout <= 1'b0;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            tcnt_q  <= tcnt_d;
            timeout <= abort_i | abort_d;
            if (grant_d) begin
                m_we    <= d_we;
                m_addr  <= d_addr;
                m_wdata <= d_wdata;
            end else if (grant_i) begin
                m_we    <= 1'b0;
                m_addr  <= i_addr;
            end
            if (ld_i) begin
                i_rdata <= m_rdata;
            end else if (abort_i) begin
                i_rdata <= ABORT_DATA;
            end
            if (ld_d) begin
                d_rdata <= m_rdata;
            end else if (abort_d) begin
                d_rdata <= ABORT_DATA;
            end
        end
    end

    // Handshake outputs decoded from the state register
    assign m_req   = (state_q == BUSY_I) || (state_q == BUSY_D);
    assign i_ready = (state_q == DONE_I);
    assign d_ready = (state_q == DONE_D);
    assign stall   = (i_req & ~i_ready) | (d_req & ~d_ready);

endmodule

// File: tb/tb_umem_arbiter.sv
// Randomized bench for umem_arbiter: two requesters and a memory with random latency
// (including never answering), checked against a transaction-level model of grants,
// burst fairness, completion timing, read data and timeouts.
module tb_umem_arbiter;

    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned MAXB  = 4;
    localparam int unsigned TO    = 8;
    localparam int          NEVER = 1000;

    logic          clk;
    logic          rst;
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_ready;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          m_req;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    logic          m_ack;
    logic          stall;
    logic          timeout;

    umem_arbiter #(
        .AW(AW), .DW(DW), .MAX_DBURST(MAXB), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ready(d_ready),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_rdata(m_rdata), .m_ack(m_ack),
        .stall(stall), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Access lifecycle as seen by the memory: free, one access outstanding, completion cycle
    typedef enum int {PH_FREE, PH_ACTIVE, PH_DONE} phase_t;

    phase_t      ph;
    int          port;      // 1 = I, 2 = D
    int          busy_n;
    int          ack_at;
    int          dcnt;
    int          load;
    logic [31:0] a_addr;
    logic [31:0] a_wdata;
    logic        a_we;
    logic        a_to;
    logic [31:0] sh_i;
    logic [31:0] sh_d;
    logic [31:0] mem [16];
    bit          i_out;
    bit          d_out;
    int          n_i_done;
    int          n_d_done;
    int          n_to;

    function automatic int pick_latency();
        int r;
        r = int'($urandom_range(0, 15));
        if (r < 10) return r % 4;
        if (r < 12) return int'(TO) - 1;
        if (r == 12) return int'(TO) - 2;
        return NEVER;
    endfunction

    task automatic model_reset();
        ph      = PH_FREE;
        port    = 0;
        busy_n  = 0;
        ack_at  = 0;
        dcnt    = 0;
        a_addr  = '0;
        a_wdata = '0;
        a_we    = 1'b0;
        a_to    = 1'b0;
        sh_i    = '0;
        sh_d    = '0;
        i_out   = 1'b0;
        d_out   = 1'b0;
    endtask

    // One clock: compare outputs, update requesters, play the memory, advance the model
    task automatic step();
        logic exp_ir;
        logic exp_dr;
        @(negedge clk);
        exp_ir = (ph == PH_DONE) && (port == 1);
        exp_dr = (ph == PH_DONE) && (port == 2);
        check("m_req", 32'(m_req), 32'(ph == PH_ACTIVE));
        if (ph == PH_ACTIVE) begin
            check("m_addr", m_addr, a_addr);
            check("m_we", 32'(m_we), 32'(a_we));
            if (a_we) check("m_wdata", m_wdata, a_wdata);
        end
        check("i_ready", 32'(i_ready), 32'(exp_ir));
        check("d_ready", 32'(d_ready), 32'(exp_dr));
        check("timeout", 32'(timeout), 32'((exp_ir | exp_dr) & a_to));
        check("stall", 32'(stall), 32'((i_req & ~exp_ir) | (d_req & ~exp_dr)));
        check("i_rdata", i_rdata, sh_i);
        check("d_rdata", d_rdata, sh_d);

        if (exp_ir) begin
            i_req = 1'b0;
            i_out = 1'b0;
            n_i_done++;
        end
        if (exp_dr) begin
            d_req = 1'b0;
            d_out = 1'b0;
            n_d_done++;
        end
        if ((exp_ir | exp_dr) & a_to) n_to++;
        // Served requester occasionally withdraws mid-access; completion must still come
        if (ph == PH_ACTIVE && $urandom_range(0, 31) == 0) begin
            if (port == 1) i_req = 1'b0;
            else d_req = 1'b0;
        end
        if (!i_out && int'($urandom_range(0, 3)) < load) begin
            i_req  = 1'b1;
            i_out  = 1'b1;
            i_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
        end
        if (!d_out && int'($urandom_range(0, 3)) < load) begin
            d_req   = 1'b1;
            d_out   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_addr  = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            d_wdata = $urandom();
        end

        m_ack   = 1'b0;
        m_rdata = $urandom();
        case (ph)
            PH_ACTIVE: begin
                if (busy_n == ack_at) begin
                    m_ack = 1'b1;
                    if (a_we) mem[a_addr[5:2]] = a_wdata;
                    else m_rdata = mem[a_addr[5:2]];
                    if (port == 1) sh_i = m_rdata;
                    else if (!a_we) sh_d = m_rdata;
                    a_to = 1'b0;
                    ph   = PH_DONE;
                end else if (busy_n == int'(TO) - 1) begin
                    if (port == 1) sh_i = 32'hDEAD_BEEF;
                    else sh_d = 32'hDEAD_BEEF;
                    a_to = 1'b1;
                    ph   = PH_DONE;
                end else begin
                    busy_n++;
                end
            end
            PH_DONE: begin
                m_ack = 1'($urandom_range(0, 1));
                ph    = PH_FREE;
            end
            default: begin
                m_ack = 1'($urandom_range(0, 1));
                if (d_req && !(i_req && dcnt >= int'(MAXB))) begin
                    port    = 2;
                    a_addr  = d_addr;
                    a_we    = d_we;
                    a_wdata = d_wdata;
                    dcnt    = i_req ? ((dcnt < int'(MAXB)) ? dcnt + 1 : dcnt) : 0;
                    ph      = PH_ACTIVE;
                    busy_n  = 0;
                    ack_at  = pick_latency();
                end else if (i_req) begin
                    port    = 1;
                    a_addr  = i_addr;
                    a_we    = 1'b0;
                    a_wdata = '0;
                    dcnt    = 0;
                    ph      = PH_ACTIVE;
                    busy_n  = 0;
                    ack_at  = pick_latency();
                end
            end
        endcase
    endtask

    initial begin
        int guard;
        int base_i;
        rst     = 1'b0;
        i_req   = 1'b0;
        i_addr  = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        m_ack   = 1'b0;
        m_rdata = '0;
        n_i_done = 0;
        n_d_done = 0;
        n_to     = 0;
        load     = 3;
        foreach (mem[k]) mem[k] = $urandom();
        model_reset();

        #12;
        check("rst_m_req", 32'(m_req), 32'd0);
        check("rst_m_we", 32'(m_we), 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_m_wdata", m_wdata, 32'd0);
        check("rst_i_ready", 32'(i_ready), 32'd0);
        check("rst_d_ready", 32'(d_ready), 32'd0);
        check("rst_i_rdata", i_rdata, 32'd0);
        check("rst_d_rdata", d_rdata, 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int c = 0; c < 2500; c++) begin
            load = (c < 1200) ? 3 : 1 + (c / 200) % 3;
            step();
        end
        check("saw_i_completions", 32'(n_i_done > 50), 32'd1);
        check("saw_d_completions", 32'(n_d_done > 50), 32'd1);
        check("saw_timeouts", 32'(n_to > 0), 32'd1);

        // Asynchronous reset in the middle of an I access
        guard = 0;
        while (!(ph == PH_ACTIVE && port == 1 && ack_at > 1) && guard < 2000) begin
            step();
            guard++;
        end
        check("reset_target_found", 32'(guard < 2000), 32'd1);
        @(posedge clk);
        #2;
        check("pre_reset_m_req", 32'(m_req), 32'd1);
        rst = 1'b0;
        #1;
        check("async_m_req", 32'(m_req), 32'd0);
        check("async_i_ready", 32'(i_ready), 32'd0);
        check("async_i_rdata", i_rdata, 32'd0);
        check("async_d_rdata", d_rdata, 32'd0);
        check("async_m_addr", m_addr, 32'd0);
        i_req = 1'b0;
        d_req = 1'b0;
        m_ack = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        base_i = n_i_done;
        load   = 2;
        for (int c = 0; c < 600; c++) step();
        check("i_after_reset", 32'(n_i_done > base_i), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
